// File: rtl/tx_sched_pkg.sv
// Shared types and helpers for the TX frame scheduler: FSM state encoding,
// default widths and a generic packed-vector slice extractor.
package tx_sched_pkg;

  localparam int unsigned N_REQ_DEF      = 4;
  localparam int unsigned LEN_W_DEF      = 16;
  localparam int unsigned MAX_LEN_DEF    = 1024;
  localparam int unsigned GAP_CYCLES_DEF = 64;

  // Widest packed per-source vector the slice helper accepts.
  localparam int unsigned SLICE_VEC_W = 512;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_TAIL,
    S_GAP
  } sched_state_e;

  // Returns field k (w bits wide, w <= 32) of a packed vector, zero-extended.
  function automatic logic [31:0] field_slice(input logic [SLICE_VEC_W-1:0] vec,
                                              input int unsigned k,
                                              input int unsigned w);
    logic [SLICE_VEC_W-1:0] sh;
    logic [31:0]            mask;
    sh   = vec >> (k * w);
    mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return sh[31:0] & mask;
  endfunction

endpackage

// File: rtl/tx_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above the pointer,
// wrapping modulo N_REQ. The pointer itself lives in the parent.
module tx_rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  int unsigned      cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      cand     = (32'(ptr_i) + off) % N_REQ;
      cand_idx = IDX_W'(cand);
      if (!valid_o && req_i[cand_idx]) begin
        valid_o         = 1'b1;
        idx_o           = cand_idx;
        gnt_o[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_frame_sched.sv
// Round-robin scheduler feeding one TX framing chain from N_REQ payload FIFOs:
// grant, burst the winner's bytes with its header fields held, then idle a gap.
module tx_frame_sched
  import tx_sched_pkg::*;
#(
  parameter int unsigned N_REQ      = N_REQ_DEF,
  parameter int unsigned LEN_W      = LEN_W_DEF,
  parameter int unsigned MAX_LEN    = MAX_LEN_DEF,
  parameter int unsigned GAP_CYCLES = GAP_CYCLES_DEF
) (
  input  logic               clk163m84,
  input  logic               rst,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [N_REQ*LEN_W-1:0] i_len,
  input  logic [N_REQ*8-1:0] i_para_type,
  input  logic [N_REQ*8-1:0] i_idenf,
  input  logic [N_REQ*8-1:0] i_rd_data,
  input  logic               i_tx_busy,
  output logic [N_REQ-1:0]   o_rd_en,
  output logic [N_REQ-1:0]   o_grant,
  output logic [7:0]         o_data,
  output logic               o_data_valid,
  output logic [7:0]         o_para_type,
  output logic [7:0]         o_info_unit_idenf,
  output logic [N_REQ-1:0]   o_frame_done,
  output logic               o_len_err
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

  sched_state_e     state_q;
  logic [N_REQ-1:0] grant_q, rd_en_q, done_q;
  logic [IDX_W-1:0] sel_q, ptr_q, ptr_next;
  logic             err_q, len_err_q, data_valid_q;
  logic [LEN_W-1:0] cnt_q, win_len;
  logic [7:0]       para_q, idenf_q;
  logic [GAP_W-1:0] gap_q;
  logic             win_bad;

  logic [N_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_valid;

  tx_rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_i   (i_req),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_comb begin
    win_len  = LEN_W'(field_slice(SLICE_VEC_W'(i_len), 32'(arb_idx), LEN_W));
    win_bad  = (win_len == '0) || (32'(win_len) > MAX_LEN);
    ptr_next = (sel_q == IDX_W'(N_REQ - 1)) ? '0 : sel_q + 1'b1;
  end

  // Length is judged and captured together on the grant edge so the error
  // pulse lines up with LOAD and the count can never disagree with the verdict.
  always_ff @(posedge clk163m84) begin
    if (rst) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      rd_en_q      <= '0;
      done_q       <= '0;
      len_err_q    <= 1'b0;
      err_q        <= 1'b0;
      data_valid_q <= 1'b0;
      sel_q        <= '0;
      ptr_q        <= '0;
      cnt_q        <= '0;
      gap_q        <= '0;
      para_q       <= '0;
      idenf_q      <= '0;
    end else begin
      done_q       <= '0;
      len_err_q    <= 1'b0;
      data_valid_q <= |rd_en_q;
      case (state_q)
        S_IDLE: begin
          if (arb_valid && !i_tx_busy) begin
            grant_q <= arb_gnt;
            sel_q   <= arb_idx;
            cnt_q   <= win_len;
            err_q   <= win_bad;
            state_q <= S_LOAD;
            if (win_bad) begin
              len_err_q <= 1'b1;
              done_q    <= arb_gnt;
            end
          end
        end
        S_LOAD: begin
          para_q  <= 8'(field_slice(SLICE_VEC_W'(i_para_type), 32'(sel_q), 8));
          idenf_q <= 8'(field_slice(SLICE_VEC_W'(i_idenf), 32'(sel_q), 8));
          if (err_q) begin
            grant_q <= '0;
            ptr_q   <= ptr_next;
            gap_q   <= '0;
            state_q <= S_GAP;
          end else begin
            rd_en_q <= grant_q;
            state_q <= S_SEND;
          end
        end
        S_SEND: begin
          if (cnt_q == LEN_W'(1)) begin
            rd_en_q <= '0;
            state_q <= S_TAIL;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_TAIL: begin
          done_q  <= grant_q;
          grant_q <= '0;
          ptr_q   <= ptr_next;
          gap_q   <= '0;
          state_q <= S_GAP;
        end
        S_GAP: begin
          if (gap_q == GAP_W'(GAP_CYCLES - 1)) state_q <= S_IDLE;
          else gap_q <= gap_q + 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // FIFO data arrives one cycle after the pop, i.e. in the o_data_valid cycle.
  assign o_data = data_valid_q
                ? 8'(field_slice(SLICE_VEC_W'(i_rd_data), 32'(sel_q), 8)) : '0;

  assign o_rd_en           = rd_en_q;
  assign o_grant           = grant_q;
  assign o_data_valid      = data_valid_q;
  assign o_para_type       = para_q;
  assign o_info_unit_idenf = idenf_q;
  assign o_frame_done      = done_q;
  assign o_len_err         = len_err_q;

endmodule

// File: tb/tb_tx_frame_sched.sv
// Scoreboard bench for tx_frame_sched: stimulus queues expected grants, bytes
// and frame completions; a negedge monitor pops and compares them.
module tb_tx_frame_sched;

  localparam int N   = 4;
  localparam int LW  = 16;
  localparam int GAP = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*LW-1:0] len_v = '0;
  logic [N*8-1:0]  para_v = '0, idenf_v = '0, rd_data = '0;
  logic            busy = 1'b0;

  logic [N-1:0] rd_en, grant, done;
  logic [7:0]   data, para_o, idenf_o;
  logic         dv, len_err;

  tx_frame_sched #(
    .N_REQ      (N),
    .LEN_W      (LW),
    .MAX_LEN    (1024),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk163m84         (clk),
    .rst               (rst),
    .i_req             (req),
    .i_len             (len_v),
    .i_para_type       (para_v),
    .i_idenf           (idenf_v),
    .i_rd_data         (rd_data),
    .i_tx_busy         (busy),
    .o_rd_en           (rd_en),
    .o_grant           (grant),
    .o_data            (data),
    .o_data_valid      (dv),
    .o_para_type       (para_o),
    .o_info_unit_idenf (idenf_o),
    .o_frame_done      (done),
    .o_len_err         (len_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] d; logic [7:0] p; logic [7:0] i; } byte_t;
  typedef struct { int src; logic err; int nrd; } done_t;

  byte_t      exp_data[$];
  done_t      exp_done[$];
  int         exp_grant[$];
  logic [7:0] fifo[N][$];

  int checks = 0, failures = 0;
  int cyc = 0;
  int grant_cyc = 0, done_cyc = 0, last_valid = 0, rd_cnt = 0;
  int bytes_seen = 0, done_cnt = 0;
  bit have_done = 1'b0, first_byte = 1'b0;
  logic [N-1:0] prev_grant = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // FIFO model: read latency 1
  always @(posedge clk) begin : fifo_model
    logic [N-1:0] re;
    re = rd_en;
    #1;
    for (int k = 0; k < N; k++)
      if (re[k] && fifo[k].size() > 0) rd_data[k*8 +: 8] = fifo[k].pop_front();
  end

  always @(negedge clk) begin : monitor
    int    g;
    byte_t e;
    done_t d;
    if (!rst) begin
      if (grant != '0 && prev_grant == '0) begin
        if (exp_grant.size() == 0) begin
          checks++; failures++;
          $display("FAIL grant_unexpected actual=%b required=none", grant);
        end else begin
          g = exp_grant.pop_front();
          chk("grant", longint'(grant), longint'(1) << g);
        end
        if (have_done) chk("gap_at_least_65", longint'((cyc - done_cyc) >= GAP + 1), 1);
        grant_cyc  = cyc;
        first_byte = 1'b1;
        rd_cnt     = 0;
      end
      prev_grant = grant;
      if (rd_en != '0) begin
        rd_cnt++;
        chk("rd_en_owner", longint'(rd_en), longint'(grant));
      end
      if (dv) begin
        if (exp_data.size() == 0) begin
          checks++; failures++;
          $display("FAIL data_unexpected actual=%0h required=none", data);
        end else begin
          e = exp_data.pop_front();
          chk("data", longint'(data), longint'(e.d));
          chk("para_type", longint'(para_o), longint'(e.p));
          chk("idenf", longint'(idenf_o), longint'(e.i));
        end
        if (first_byte) begin
          chk("first_byte_latency", cyc - grant_cyc, 2);
          first_byte = 1'b0;
        end
        last_valid = cyc;
        bytes_seen++;
      end
      if (done != '0) begin
        if (exp_done.size() == 0) begin
          checks++; failures++;
          $display("FAIL done_unexpected actual=%b required=none", done);
        end else begin
          d = exp_done.pop_front();
          chk("done_vec", longint'(done), longint'(1) << d.src);
          chk("len_err", longint'(len_err), longint'(d.err));
          chk("rd_count", rd_cnt, d.nrd);
          if (d.err) chk("err_latency", cyc - grant_cyc, 0);
          else begin
            chk("done_after_last_byte", cyc - last_valid, 1);
            chk("frame_span", cyc - grant_cyc, d.nrd + 2);
          end
        end
        done_cyc  = cyc;
        have_done = 1'b1;
        done_cnt++;
      end else if (len_err) begin
        checks++; failures++;
        $display("FAIL len_err_stray actual=1 required=0");
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic set_src(input int src, input int n, input logic [7:0] p, input logic [7:0] id);
    len_v[src*LW +: LW]  = LW'(n);
    para_v[src*8 +: 8]   = p;
    idenf_v[src*8 +: 8]  = id;
  endtask

  task automatic issue(input int src, input int n, input logic [7:0] p, input logic [7:0] id,
                       input logic [7:0] base, input logic err);
    exp_grant.push_back(src);
    if (!err)
      for (int i = 0; i < n; i++) begin
        fifo[src].push_back(8'(base + i));
        exp_data.push_back('{d: 8'(base + i), p: p, i: id});
      end
    exp_done.push_back('{src: src, err: err, nrd: err ? 0 : n});
  endtask

  task automatic flush();
    exp_data.delete();
    exp_done.delete();
    exp_grant.delete();
    for (int k = 0; k < N; k++) fifo[k].delete();
    prev_grant = '0;
    have_done  = 1'b0;
    first_byte = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    chk(name, longint'({grant, rd_en, data, dv, para_o, idenf_o, done, len_err}), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush();
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset_outputs");
    #1 rst = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int n = 0;
    while (done_cnt < target && n < budget) begin step(1); n++; end
    if (done_cnt < target) begin
      checks++; failures++;
      $display("FAIL %s_timeout actual=%0d required=%0d", name, done_cnt, target);
    end
  endtask

  task automatic wait_bytes(input int target, input int budget, input string name);
    int n = 0;
    while (bytes_seen < target && n < budget) begin step(1); n++; end
    if (bytes_seen < target) begin
      checks++; failures++;
      $display("FAIL %s_timeout actual=%0d required=%0d", name, bytes_seen, target);
    end
  endtask

  initial begin
    int b0;
    do_reset();

    // 1: single frame on source 0
    set_src(0, 5, 8'hA1, 8'h3C);
    issue(0, 5, 8'hA1, 8'h3C, 8'h50, 1'b0);
    req = 4'b0001;
    wait_done(done_cnt + 1, 40, "single");
    req = '0;
    step(70);

    do_reset();

    // 2: round robin 0,1,2,3,0 then wrap behaviour
    for (int k = 0; k < N; k++) set_src(k, 2, 8'(8'hB0 + k), 8'(8'hC0 + k));
    issue(0, 2, 8'hB0, 8'hC0, 8'h00, 1'b0);
    issue(1, 2, 8'hB1, 8'hC1, 8'h10, 1'b0);
    issue(2, 2, 8'hB2, 8'hC2, 8'h20, 1'b0);
    issue(3, 2, 8'hB3, 8'hC3, 8'h30, 1'b0);
    issue(0, 2, 8'hB0, 8'hC0, 8'h40, 1'b0);
    req = 4'b1111;
    wait_done(done_cnt + 5, 5 * 80, "rr_all");
    req = '0;
    step(70);
    issue(2, 2, 8'hB2, 8'hC2, 8'h60, 1'b0);
    req = 4'b0100;
    wait_done(done_cnt + 1, 80, "rr_src2");
    issue(0, 2, 8'hB0, 8'hC0, 8'h70, 1'b0);
    issue(2, 2, 8'hB2, 8'hC2, 8'h80, 1'b0);
    req = 4'b0101;
    wait_done(done_cnt + 2, 160, "rr_0101");
    req = 4'b1101;
    issue(3, 2, 8'hB3, 8'hC3, 8'h90, 1'b0);
    wait_done(done_cnt + 1, 80, "rr_1101");
    req = '0;
    step(70);

    // 3: length errors on source 1, then the maximum legal length
    set_src(1, 0, 8'hD1, 8'hE1);
    issue(1, 0, 8'hD1, 8'hE1, 8'h00, 1'b1);
    req = 4'b0010;
    wait_done(done_cnt + 1, 40, "len0");
    req = '0;
    step(70);
    set_src(1, 1025, 8'hD2, 8'hE2);
    issue(1, 1025, 8'hD2, 8'hE2, 8'h00, 1'b1);
    req = 4'b0010;
    wait_done(done_cnt + 1, 40, "len1025");
    req = '0;
    step(70);
    set_src(1, 1024, 8'hD3, 8'hE3);
    issue(1, 1024, 8'hD3, 8'hE3, 8'h07, 1'b0);
    req = 4'b0010;
    wait_done(done_cnt + 1, 1200, "len1024");
    req = '0;
    step(70);

    // 4: busy hold-off on source 2
    busy = 1'b1;
    set_src(2, 3, 8'h5A, 8'h6B);
    issue(2, 3, 8'h5A, 8'h6B, 8'hF0, 1'b0);
    req = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      step(4);
      chk("busy_no_grant", longint'({grant, rd_en}), 0);
    end
    busy = 1'b0;
    @(negedge clk);
    chk("busy_release_grant", longint'(grant), 4'b0100);
    #1;
    step(1);
    busy = 1'b1;
    wait_done(done_cnt + 1, 40, "busy");
    busy = 1'b0;
    req = '0;
    step(70);

    // 5: reset on the 3rd byte; pointer must restart at 0
    set_src(0, 8, 8'h11, 8'h22);
    set_src(3, 2, 8'h33, 8'h44);
    issue(0, 8, 8'h11, 8'h22, 8'hA0, 1'b0);
    b0 = bytes_seen;
    req = 4'b0001;
    wait_bytes(b0 + 3, 40, "pre_reset");
    rst = 1'b1;
    flush();
    @(negedge clk);
    check_all_zero("midframe_reset_outputs");
    #1 rst = 1'b0;
    issue(0, 8, 8'h11, 8'h22, 8'hC8, 1'b0);
    req = 4'b1001;
    wait_done(done_cnt + 1, 40, "post_reset");
    req = '0;
    step(70);

    // 6: source 2 withdraws its request mid-frame
    set_src(2, 6, 8'h77, 8'h88);
    issue(2, 6, 8'h77, 8'h88, 8'h31, 1'b0);
    b0 = bytes_seen;
    req = 4'b0100;
    wait_bytes(b0 + 1, 40, "withdraw_start");
    req = '0;
    wait_done(done_cnt + 1, 40, "withdraw");
    step(10);

    chk("leftover_expectations", exp_data.size() + exp_done.size() + exp_grant.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
